mod_addsub: RTL and testbench

Modular adder/subtractor for the 1027-bit datapath: computes (a + b) mod m or (a − b) mod m for a, b < m. It is the initiator of the mpadder start/done handshake. It owns one mpadder instance and sequences one or two raw add/sub passes through it, then applies the conditional correction with m. It sits between the exponentiation/Montgomery control and the raw multi-precision adder.

---
 rtl/mod_addsub_pkg.sv | 20 ++
 rtl/mpadder.sv | 66 ++++++
 rtl/mod_addsub.sv | 100 ++++++++++
 tb/tb_mod_addsub.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mod_addsub_pkg.sv
// Shared definitions for the modular add/sub datapath: widths, FSM encoding
// and op-type constants used by mod_addsub and its raw adder.
package mod_addsub_pkg;

  localparam int WIDTH       = 1027;
  localparam int MPADD_CHUNK = 128;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    OP1,
    WAIT1,
    OP2,
    WAIT2,
    FIN
  } state_t;

endpackage

// File: rtl/mpadder.sv
// Multi-precision raw adder/subtractor: a +/- b over WIDTH+1 bits, processed
// CHUNK bits per cycle with a start/done handshake. Result bit WIDTH is the carry/borrow.
module mpadder #(
  parameter int WIDTH = mod_addsub_pkg::WIDTH,
  parameter int CHUNK = mod_addsub_pkg::MPADD_CHUNK
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH:0]   result,
  output logic             done
);

  localparam int NCH   = (WIDTH + CHUNK) / CHUNK;
  localparam int PW    = NCH * CHUNK;
  localparam int CNT_W = $clog2(NCH + 1);

  logic [PW-1:0]    a_q, b_q, res_q;
  logic             carry_q, busy_q, done_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CHUNK:0]   sum;

  // Subtraction is a + ~b + 1; zero-extending b before inverting makes the
  // upper bits all ones, so bit WIDTH of the result reads as the borrow.
  assign sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};

  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too, so an aborted pass never leaves
    // stale operands behind; drop them from the reset branch if area matters.
    if (!resetn) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        a_q     <= PW'(in_a);
        b_q     <= subtract ? ~PW'(in_b) : PW'(in_b);
        carry_q <= subtract;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end else if (busy_q) begin
        res_q   <= {sum[CHUNK-1:0], res_q[PW-1:CHUNK]};
        a_q     <= a_q >> CHUNK;
        b_q     <= b_q >> CHUNK;
        carry_q <= sum[CHUNK];
        cnt_q   <= cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NCH - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign result = res_q[WIDTH:0];
  assign done   = done_q;

endmodule

// File: rtl/mod_addsub.sv
// Modular adder/subtractor: (a +/- b) mod m for a, b < m, sequencing one or two
// raw passes through mpadder and applying the conditional correction with m.
module mod_addsub
  import mod_addsub_pkg::*;
#(
  parameter int WIDTH = mod_addsub_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  state_t           state_q;
  logic             add_start_q, add_sub_q, sub_q, done_q;
  logic [WIDTH-1:0] add_a_q, add_b_q, m_q, p1_q, result_q;
  logic [WIDTH:0]   add_res;
  logic             add_done;

  mpadder #(.WIDTH(WIDTH)) u_mpadder (
    .clk      (clk),
    .resetn   (resetn),
    .start    (add_start_q),
    .subtract (add_sub_q),
    .in_a     (add_a_q),
    .in_b     (add_b_q),
    .result   (add_res),
    .done     (add_done)
  );

  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    if (!resetn) begin
      state_q     <= IDLE;
      add_start_q <= 1'b0;
      add_sub_q   <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      m_q         <= '0;
      sub_q       <= 1'b0;
      p1_q        <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      add_start_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            add_a_q     <= in_a;
            add_b_q     <= in_b;
            add_sub_q   <= subtract;
            m_q         <= in_m;
            sub_q       <= subtract;
            add_start_q <= 1'b1;
            state_q     <= OP1;
          end
        end
        OP1: state_q <= WAIT1;
        WAIT1: begin
          if (add_done) begin
            p1_q <= add_res[WIDTH-1:0];
            if (sub_q == SUB && !add_res[WIDTH]) begin
              result_q <= add_res[WIDTH-1:0];
              done_q   <= 1'b1;
              state_q  <= FIN;
            end else begin
              // Add path tries s - m; borrowing sub path adds m back.
              add_a_q     <= add_res[WIDTH-1:0];
              add_b_q     <= m_q;
              add_sub_q   <= (sub_q == ADD);
              add_start_q <= 1'b1;
              state_q     <= OP2;
            end
          end
        end
        OP2: state_q <= WAIT2;
        WAIT2: begin
          if (add_done) begin
            result_q <= (sub_q == ADD && add_res[WIDTH]) ? p1_q : add_res[WIDTH-1:0];
            done_q   <= 1'b1;
            state_q  <= FIN;
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_mod_addsub.sv
// Directed-vector and random self-checking bench for mod_addsub.
module tb_mod_addsub;

  localparam int W      = 1027;
  localparam int L      = 10;            // mpadder: 9 chunks of 128 bits + capture cycle
  localparam int BUDGET = 3 * L + 10;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] m;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic         subtract;
  logic [W-1:0] in_a, in_b, in_m;
  logic [W-1:0] result;
  logic         done;

  int n_vec = 0;
  int n_bad = 0;

  mod_addsub #(.WIDTH(W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .subtract (subtract),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_m     (in_m),
    .result   (result),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (low 128 bits)", name, act[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [W-1:0] rand_wide();
    logic [1055:0] t;
    for (int i = 0; i < 33; i++) t[i*32 +: 32] = $urandom();
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] model(input logic sub, input logic [W-1:0] a, b, m);
    logic [W:0] t;
    if (!sub) begin
      t = {1'b0, a} + {1'b0, b};
      if (t >= {1'b0, m}) t = t - {1'b0, m};
    end else if (a >= b) begin
      t = {1'b0, a - b};
    end else begin
      t = {1'b0, a} + {1'b0, m} - {1'b0, b};
    end
    return t[W-1:0];
  endfunction

  // One request starting at the next falling edge; inputs are scrambled right
  // after the accepting edge. Returns the cycle index of done (-1 on timeout).
  task automatic do_req(input logic sub, input logic [W-1:0] a, b, m,
                        output logic [W-1:0] res, output int lat);
    @(negedge clk);
    check("done_width", {{W{1'b0}}, done}, '0);
    start = 1'b1; subtract = sub; in_a = a; in_b = b; in_m = m;
    res = '0;
    lat = -1;
    for (int n = 1; n <= BUDGET; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0; subtract = ~sub; in_a = ~a; in_b = ~b; in_m = ~m;
      end
      if (done) begin
        lat = n;
        res = result;
        break;
      end
    end
  endtask

  initial begin
    vec_t         vecs[$];
    logic [W-1:0] p, big, res, a, b, m;
    int           lat, dc, first_n;
    logic         sub;

    resetn = 1'b0; start = 1'b0; subtract = 1'b0;
    in_a = '0; in_b = '0; in_m = '0;

    p = '0; p[1025] = 1'b1;
    big = '1; big = big >> 1;
    vecs.push_back('{1'b0, W'(7),  W'(9),  W'(13), W'(3),  2*L+3});
    vecs.push_back('{1'b0, W'(0),  W'(0),  W'(13), W'(0),  2*L+3});
    vecs.push_back('{1'b1, W'(3),  W'(9),  W'(13), W'(7),  2*L+3});
    vecs.push_back('{1'b1, W'(9),  W'(3),  W'(13), W'(6),  L+2});
    vecs.push_back('{1'b0, p,      p,      p + 1,  p - 1,  2*L+3});
    vecs.push_back('{1'b0, big-1,  big-1,  big,    big-2,  2*L+3});
    vecs.push_back('{1'b1, W'(5),  W'(5),  W'(13), W'(0),  L+2});
    vecs.push_back('{1'b1, W'(0),  W'(12), W'(13), W'(1),  2*L+3});
    vecs.push_back('{1'b0, W'(12), W'(1),  W'(13), W'(0),  2*L+3});
    vecs.push_back('{1'b0, W'(6),  W'(6),  W'(13), W'(12), 2*L+3});

    repeat (3) @(negedge clk);
    check("reset_result", {1'b0, result}, '0);
    check("reset_done", {{W{1'b0}}, done}, '0);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      do_req(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].m, res, lat);
      check($sformatf("vec%0d_result", i), {1'b0, res}, {1'b0, vecs[i].exp});
      check($sformatf("vec%0d_latency", i), W'(lat), W'(vecs[i].lat));
    end

    // start pulsed again during WAIT1 must be ignored
    @(negedge clk);
    start = 1'b1; subtract = 1'b0; in_a = W'(7); in_b = W'(9); in_m = W'(13);
    dc = 0; first_n = -1; res = '0;
    for (int n = 1; n <= BUDGET; n++) begin
      @(negedge clk);
      if (n == 1) begin start = 1'b0; in_a = W'(1); in_b = W'(2); end
      if (n == 3) begin start = 1'b1; subtract = 1'b1; in_a = W'(2); in_b = W'(8); end
      if (n == 4) start = 1'b0;
      if (done) begin
        dc++;
        if (first_n < 0) begin first_n = n; res = result; end
      end
    end
    check("ignore_done_count", W'(dc), W'(1));
    check("ignore_latency", W'(first_n), W'(2*L+3));
    check("ignore_result", {1'b0, res}, W'(3));

    // reset pulse during WAIT2 (with a start alongside it) aborts the request
    @(negedge clk);
    start = 1'b1; subtract = 1'b0; in_a = W'(7); in_b = W'(9); in_m = W'(13);
    dc = 0;
    for (int n = 1; n <= BUDGET; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == L + 5) begin resetn = 1'b0; start = 1'b1; end
      if (n == L + 6) begin resetn = 1'b1; start = 1'b0; end
      if (done) dc++;
    end
    check("abort_done_count", W'(dc), '0);
    check("abort_result", {1'b0, result}, '0);
    do_req(1'b0, W'(5), W'(5), W'(13), res, lat);
    check("post_reset_result", {1'b0, res}, W'(10));
    check("post_reset_latency", W'(lat), W'(2*L+3));

    for (int i = 0; i < 200; i++) begin
      m = rand_wide();
      m[W-1] = 1'b0;
      m = m >> $urandom_range(0, 1020);
      if (m == '0) m = W'(1);
      a = rand_wide() % m;
      b = rand_wide() % m;
      sub = 1'($urandom_range(0, 1));
      do_req(sub, a, b, m, res, lat);
      check($sformatf("rand%0d_result", i), {1'b0, res}, {1'b0, model(sub, a, b, m)});
      check($sformatf("rand%0d_latency", i), W'(lat), W'((sub && a >= b) ? L + 2 : 2*L + 3));
    end
    @(negedge clk);
    check("final_done_width", {{W{1'b0}}, done}, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
